// File: rtl/stream_arb_rr_if.sv
//------------------------------------------------------------------------------
// stream_arb_rr_if
// Handshake bundle for the two-source round-robin stream arbiter.
//   Sources A/B : valid_in_x, data_in_x, eop_in_x  -> arbiter
//                 ready_out_x                      <- arbiter
//   Sink        : valid_out, data_out, eop_out, src_out <- arbiter
//                 ready_in                              -> arbiter
//   Status      : grant (00 IDLE, 01 GRANT_A, 10 GRANT_B) <- arbiter
// Modports:
//   master : the arbiter itself (drives ready_out_x, the output beat, grant)
//   slave  : the environment (drives source beats and sink ready)
//------------------------------------------------------------------------------
interface stream_arb_rr_if #(
   parameter int DATA_WIDTH = 26
) ();
   logic                  valid_in_a;
   logic                  valid_in_b;
   logic [DATA_WIDTH-1:0] data_in_a;
   logic [DATA_WIDTH-1:0] data_in_b;
   logic                  eop_in_a;
   logic                  eop_in_b;
   logic                  ready_out_a;
   logic                  ready_out_b;
   logic                  ready_in;
   logic                  valid_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  eop_out;
   logic                  src_out;
   logic [1:0]            grant;

   modport master (
      input  valid_in_a, valid_in_b, data_in_a, data_in_b,
      input  eop_in_a, eop_in_b, ready_in,
      output ready_out_a, ready_out_b, valid_out, data_out,
      output eop_out, src_out, grant
   );

   modport slave (
      output valid_in_a, valid_in_b, data_in_a, data_in_b,
      output eop_in_a, eop_in_b, ready_in,
      input  ready_out_a, ready_out_b, valid_out, data_out,
      input  eop_out, src_out, grant
   );
endinterface

// File: rtl/stream_arb_rr.sv
//------------------------------------------------------------------------------
// stream_arb_rr
// Two-source round-robin stream arbiter with a single registered output beat.
// A grant lasts until the granted source ends its packet (eop) or, unless
// packet lock is enabled, until BURST_LEN beats have been sent. Each grant
// starts with a one-cycle arbitration bubble in IDLE.
//
// Parameters:
//   DATA_WIDTH : beat payload width in bits
//   BURST_LEN  : maximum beats per grant (1..255), unused with packet lock
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stream_arb_rr_if.master (source/sink handshakes, grant status)
// Configuration macro:
//   STREAM_ARB_PKT_LOCK_EN : defined -> grants end only on eop (no packet
//                            interleaving); undefined -> grants also end
//                            after BURST_LEN beats.
//------------------------------------------------------------------------------
module stream_arb_rr #(
   parameter int DATA_WIDTH = 26,
   parameter int BURST_LEN  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   stream_arb_rr_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT_A = 2'b01,
      GRANT_B = 2'b10
   } state_t;

   localparam logic [7:0] BURST_LIM = 8'(BURST_LEN);

   state_t                state;
   logic                  last_grant;   // 0 = A was granted last, 1 = B
   logic [7:0]            beat_cnt;

   // output register stage
   logic                  valid_out_p0;
   logic [DATA_WIDTH-1:0] data_out_p0;
   logic                  eop_out_p0;
   logic                  src_out_p0;

   logic                  out_free;
   logic                  ready_a;
   logic                  ready_b;
   logic                  xfer_a;
   logic                  xfer_b;
   logic                  xfer;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_eop;
   logic [7:0]            beat_cnt_nxt;
   logic                  grant_done;

   always_comb begin
      // the output slot can take a beat if empty or being drained this edge
      out_free     = ~valid_out_p0 | bus.ready_in;
      ready_a      = (state == GRANT_A) & out_free;
      ready_b      = (state == GRANT_B) & out_free;
      xfer_a       = bus.valid_in_a & ready_a;
      xfer_b       = bus.valid_in_b & ready_b;
      xfer         = xfer_a | xfer_b;
      sel_data     = xfer_b ? bus.data_in_b : bus.data_in_a;
      sel_eop      = xfer_b ? bus.eop_in_b  : bus.eop_in_a;
      // saturate so a long locked packet cannot wrap the counter
      beat_cnt_nxt = (beat_cnt == 8'hFF) ? beat_cnt : beat_cnt + 8'd1;
`ifdef STREAM_ARB_PKT_LOCK_EN
      grant_done   = xfer & sel_eop;
`else
      grant_done   = xfer & (sel_eop | (beat_cnt_nxt == BURST_LIM));
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_grant   <= 1'b1;          // A wins the first tie
         beat_cnt     <= 8'd0;
         valid_out_p0 <= 1'b0;
         data_out_p0  <= '0;
         eop_out_p0   <= 1'b0;
         src_out_p0   <= 1'b0;
      end else begin
         // arbitration and grant release
         case (state)
            IDLE: begin
               // A wins when alone, or on a tie when B had the last grant
               if (bus.valid_in_a & (~bus.valid_in_b | last_grant)) begin
                  state      <= GRANT_A;
                  last_grant <= 1'b0;
                  beat_cnt   <= 8'd0;
               end else if (bus.valid_in_b) begin
                  state      <= GRANT_B;
                  last_grant <= 1'b1;
                  beat_cnt   <= 8'd0;
               end
            end
            GRANT_A, GRANT_B: begin
               if (xfer) begin
                  beat_cnt <= beat_cnt_nxt;
               end
               if (grant_done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // output register: load wins over drain, giving bubble-free handoff
         if (xfer) begin
            valid_out_p0 <= 1'b1;
            data_out_p0  <= sel_data;
            eop_out_p0   <= sel_eop;
            src_out_p0   <= xfer_b;
         end else if (bus.ready_in & valid_out_p0) begin
            valid_out_p0 <= 1'b0;
         end
      end
   end

   assign bus.ready_out_a = ready_a;
   assign bus.ready_out_b = ready_b;
   assign bus.valid_out   = valid_out_p0;
   assign bus.data_out    = data_out_p0;
   assign bus.eop_out     = eop_out_p0;
   assign bus.src_out     = src_out_p0;
   assign bus.grant       = state;

endmodule

// File: tb/tb_stream_arb_rr.sv
//------------------------------------------------------------------------------
// tb_stream_arb_rr
// Directed bench for stream_arb_rr (BURST_LEN = 4). Source beats come from
// per-source queues advanced on each accepted transfer; beats taken by the
// sink are logged as {src, eop, data} and compared to hand-derived orders.
//------------------------------------------------------------------------------
module tb_stream_arb_rr;

   localparam int DW = 26;
   localparam int BL = 4;

   typedef logic [DW:0]   beat_t;   // {eop, data}
   typedef logic [DW+1:0] rx_t;     // {src, eop, data}

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   stream_arb_rr_if #(.DATA_WIDTH(DW)) bif ();

   stream_arb_rr #(
      .DATA_WIDTH (DW),
      .BURST_LEN  (BL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   beat_t qa[$];
   beat_t qb[$];
   rx_t   rx[$];
   rx_t   exp_seq[7];
   int    n_cmp  = 0;
   int    n_fail = 0;

   function automatic beat_t mk(input logic eop, input logic [DW-1:0] d);
      return {eop, d};
   endfunction

   function automatic rx_t mkrx(input logic src, input logic eop, input logic [DW-1:0] d);
      return {src, eop, d};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drive each source from the head of its queue
   task automatic present();
      if (qa.size() > 0) begin
         bif.valid_in_a = 1'b1;
         bif.data_in_a  = qa[0][DW-1:0];
         bif.eop_in_a   = qa[0][DW];
      end else begin
         bif.valid_in_a = 1'b0;
         bif.data_in_a  = '0;
         bif.eop_in_a   = 1'b0;
      end
      if (qb.size() > 0) begin
         bif.valid_in_b = 1'b1;
         bif.data_in_b  = qb[0][DW-1:0];
         bif.eop_in_b   = qb[0][DW];
      end else begin
         bif.valid_in_b = 1'b0;
         bif.data_in_b  = '0;
         bif.eop_in_b   = 1'b0;
      end
   endtask

   // one clock: sample handshakes before the edge, check/drive 1 after it
   task automatic cycle();
      logic xa, xb, sk;
      #3;
      xa = bif.valid_in_a & bif.ready_out_a;
      xb = bif.valid_in_b & bif.ready_out_b;
      sk = bif.valid_out & bif.ready_in;
      if (sk) rx.push_back({bif.src_out, bif.eop_out, bif.data_out});
      @(posedge clk);
      #1;
      if (xa) void'(qa.pop_front());
      if (xb) void'(qb.pop_front());
      present();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      qa.delete();
      qb.delete();
      present();
      bif.ready_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rx.delete();
   endtask

   initial begin
      bif.ready_in = 1'b1;
      present();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid_out", 64'(bif.valid_out), 64'd0);
      chk("rst_grant", 64'(bif.grant), 64'd0);
      chk("rst_data_out", 64'(bif.data_out), 64'd0);
      chk("rst_eop_out", 64'(bif.eop_out), 64'd0);
      chk("rst_src_out", 64'(bif.src_out), 64'd0);
      chk("rst_ready_a", 64'(bif.ready_out_a), 64'd0);
      chk("rst_ready_b", 64'(bif.ready_out_b), 64'd0);
      rst_n = 1'b1;

      // A alone, three beats, eop on the third
      qa.push_back(mk(1'b0, 26'h1));
      qa.push_back(mk(1'b0, 26'h2));
      qa.push_back(mk(1'b1, 26'h3));
      present();
      cycle();
      chk("a3_grant_a", 64'(bif.grant), 64'd1);
      chk("a3_bubble_valid", 64'(bif.valid_out), 64'd0);
      chk("a3_ready_a", 64'(bif.ready_out_a), 64'd1);
      chk("a3_ready_b", 64'(bif.ready_out_b), 64'd0);
      cycle();
      chk("a3_data1", 64'(bif.data_out), 64'h1);
      chk("a3_valid1", 64'(bif.valid_out), 64'd1);
      cycle();
      chk("a3_data2", 64'(bif.data_out), 64'h2);
      cycle();
      chk("a3_data3", 64'(bif.data_out), 64'h3);
      chk("a3_eop3", 64'(bif.eop_out), 64'd1);
      chk("a3_grant_idle", 64'(bif.grant), 64'd0);
      cycle();
      chk("a3_drained", 64'(bif.valid_out), 64'd0);
      chk("a3_rx_count", 64'(rx.size()), 64'd3);

      // both valid from reset, single-beat packets: A,B,A,B
      do_reset();
      for (int i = 0; i < 2; i++) begin
         qa.push_back(mk(1'b1, 26'(32'h100 + i)));
         qb.push_back(mk(1'b1, 26'(32'h200 + i)));
      end
      present();
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("rr_grant", 64'(bif.grant), (k % 2 == 0) ? 64'd1 : 64'd2);
         cycle();
         chk("rr_src", 64'(bif.src_out), 64'(k % 2));
         chk("rr_data", 64'(bif.data_out),
             (k % 2 == 0) ? 64'(32'h100 + k / 2) : 64'(32'h200 + k / 2));
      end

      // sink stall holding 0x2A for four cycles
      do_reset();
      qa.push_back(mk(1'b0, 26'h2A));
      qa.push_back(mk(1'b1, 26'h2B));
      present();
      cycle();
      cycle();
      chk("stall_load", 64'(bif.data_out), 64'h2A);
      bif.ready_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("stall_data", 64'(bif.data_out), 64'h2A);
         chk("stall_valid", 64'(bif.valid_out), 64'd1);
         chk("stall_ready_a", 64'(bif.ready_out_a), 64'd0);
      end
      bif.ready_in = 1'b1;
      cycle();
      chk("stall_swap_data", 64'(bif.data_out), 64'h2B);
      chk("stall_swap_valid", 64'(bif.valid_out), 64'd1);
      cycle();
      chk("stall_end_valid", 64'(bif.valid_out), 64'd0);
      chk("stall_rx_count", 64'(rx.size()), 64'd2);
      chk("stall_rx0", 64'(rx[0]), 64'(mkrx(1'b0, 1'b0, 26'h2A)));
      chk("stall_rx1", 64'(rx[1]), 64'(mkrx(1'b0, 1'b1, 26'h2B)));

      // six-beat A packet against a waiting B with BURST_LEN = 4
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         qa.push_back(mk(i == 6, 26'(32'h300 + i)));
      end
      qb.push_back(mk(1'b1, 26'h3B0));
      present();
`ifdef STREAM_ARB_PKT_LOCK_EN
      for (int i = 0; i < 6; i++) exp_seq[i] = mkrx(1'b0, i == 5, 26'(32'h301 + i));
      exp_seq[6] = mkrx(1'b1, 1'b1, 26'h3B0);
`else
      for (int i = 0; i < 4; i++) exp_seq[i] = mkrx(1'b0, 1'b0, 26'(32'h301 + i));
      exp_seq[4] = mkrx(1'b1, 1'b1, 26'h3B0);
      exp_seq[5] = mkrx(1'b0, 1'b0, 26'h305);
      exp_seq[6] = mkrx(1'b0, 1'b1, 26'h306);
`endif
      repeat (12) cycle();
      chk("burst_rx_count", 64'(rx.size()), 64'd7);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("burst_rx%0d", i), 64'(rx[i]), 64'(exp_seq[i]));
      end

      // asynchronous reset in the middle of a B packet
      do_reset();
      qb.push_back(mk(1'b0, 26'h401));
      qb.push_back(mk(1'b0, 26'h402));
      qb.push_back(mk(1'b1, 26'h403));
      present();
      cycle();
      chk("ar_grant_b", 64'(bif.grant), 64'd2);
      cycle();
      chk("ar_valid_pre", 64'(bif.valid_out), 64'd1);
      chk("ar_src_pre", 64'(bif.src_out), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid_async", 64'(bif.valid_out), 64'd0);
      chk("ar_grant_async", 64'(bif.grant), 64'd0);
      chk("ar_data_async", 64'(bif.data_out), 64'd0);
      chk("ar_ready_b_async", 64'(bif.ready_out_b), 64'd0);
      qa.delete();
      qb.delete();
      present();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rx.delete();
      qa.push_back(mk(1'b1, 26'h501));
      qb.push_back(mk(1'b1, 26'h502));
      present();
      cycle();
      chk("ar_tie_grant_a", 64'(bif.grant), 64'd1);
      cycle();
      chk("ar_tie_src", 64'(bif.src_out), 64'd0);
      chk("ar_tie_data", 64'(bif.data_out), 64'h501);
      cycle();
      chk("ar_next_grant_b", 64'(bif.grant), 64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_arb_rr.md
STREAM_ARB_RR -- requirements
Module: stream_arb_rr

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 26, giving the beat payload width in bits.
REQ-002 The block SHALL have parameter BURST_LEN, default 16, range 1..255, giving the maximum beats per grant.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 valid_in_a, valid_in_b  input  1 each  source A/B beat valid.
REQ-006 data_in_a, data_in_b  input  DATA_WIDTH each  source A/B payload.
REQ-007 eop_in_a, eop_in_b  input  1 each  source A/B end-of-packet flag.
REQ-008 ready_out_a, ready_out_b  output  1 each  source A/B beat accepted when high with valid.
REQ-009 ready_in  input  1  downstream sink ready.
REQ-010 valid_out  output  1  output register holds a beat.
REQ-011 data_out  output  DATA_WIDTH  registered payload.
REQ-012 eop_out  output  1  registered end-of-packet.
REQ-013 src_out  output  1  source of the held beat (0=A, 1=B).
REQ-014 grant  output  2  state: 00 IDLE, 01 GRANT_A, 10 GRANT_B.

Function
REQ-015 The FSM SHALL have states IDLE, GRANT_A and GRANT_B.
REQ-016 In IDLE, with exactly one valid_in_x high, the FSM SHALL move to GRANT_x on the next edge.
REQ-017 In IDLE, with both valids high, the FSM SHALL grant the source not recorded in last_grant.
- last_grant SHALL update on every entry into a GRANT state.
REQ-018 In IDLE, both ready_out SHALL be 0 and no beat SHALL transfer.
- This gives a fixed one-cycle arbitration bubble per grant.
REQ-019 ready_out_x SHALL equal (state==GRANT_x) & (~valid_out | ready_in), combinationally.
REQ-020 On a transfer (valid_in_x & ready_out_x), the block SHALL load data_out, eop_out and src_out, and set valid_out=1 at that edge.
REQ-021 On ready_in & valid_out with no new transfer, the block SHALL clear valid_out at that edge.
REQ-022 A simultaneous drain and load SHALL leave valid_out=1 holding the new beat, with no bubble.
REQ-023 An 8-bit beat counter SHALL clear on grant entry and increment on each transfer.
REQ-024 GRANT_x SHALL return to IDLE on a transfer that completes the grant (REQ-031/032).
REQ-025 A grant SHALL NOT return to IDLE while valid_in_x is low; it waits.
REQ-026 data_out SHALL remain stable while valid_out=1 and ready_in=0.

Reset
REQ-027 On rst_n low, the block SHALL immediately clear valid_out, data_out, eop_out, src_out and the counter.
REQ-028 On rst_n low, the state SHALL go to IDLE, grant=00 and last_grant=B, so A wins the first tie.
REQ-029 Reset mid-packet SHALL discard the held beat; after release, arbitration SHALL restart from IDLE.

Configuration
REQ-030 The macro STREAM_ARB_PKT_LOCK_EN SHALL select the grant-release rule.
REQ-031 With STREAM_ARB_PKT_LOCK_EN defined, a grant SHALL end only on a transfer with eop_in_x=1.
- BURST_LEN SHALL be ignored, so packets are never interleaved.
REQ-032 With STREAM_ARB_PKT_LOCK_EN undefined, a grant SHALL end on an eop transfer or on the transfer that makes the counter equal BURST_LEN.
- Interleaving at BURST_LEN boundaries SHALL be permitted.

Verification
REQ-033 Stimulus: A only sends 3 beats 0x1,0x2,0x3 (eop on third), ready_in=1.
- Response: grant=01 one cycle after valid; data_out 0x1,0x2,0x3 on consecutive cycles; grant=00 after the eop beat.
REQ-034 Stimulus: both valid from reset, single-beat packets with eop=1.
- Response: grants alternate A,B,A,B; src_out 0,1,0,1.
REQ-035 Stimulus: ready_in=0 for 4 cycles with valid_out=1 holding 0x2A.
- Response: data_out stays 0x2A; ready_out_a=0; no beat lost or duplicated when ready_in returns.
REQ-036 Stimulus: macro undefined, BURST_LEN=4, A sends a 6-beat packet, B valid.
- Response: A sends 4 beats, then B is granted, then A's remaining 2 beats follow.
- Stimulus repeated with macro defined.
- Response: all 6 A beats go first, then B.
REQ-037 Stimulus: rst_n asserted asynchronously mid-packet in GRANT_B.
- Response: valid_out=0 and grant=00 without waiting for a clock edge; after release, a tie grants A first.
